// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: memory handshakes, decoded selects and status of the multi-cycle control FSM.
interface multicycle_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        br_taken;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [1:0]  wb_sel;
    logic [1:0]  pc_sel;
    logic        pc_we;
    logic        reg_we;
    logic        retire;
    logic        trap;
    logic [2:0]  state;
    modport master (
        output imem_req, dmem_req, dmem_we, ir, opcode, alu_a_sel, alu_b_sel,
               wb_sel, pc_sel, pc_we, reg_we, retire, trap, state,
        input  imem_ack, imem_rdata, dmem_ack, br_taken
    );
    modport slave (
        input  imem_req, dmem_req, dmem_we, ir, opcode, alu_a_sel, alu_b_sel,
               wb_sel, pc_sel, pc_we, reg_we, retire, trap, state,
        output imem_ack, imem_rdata, dmem_ack, br_taken
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM sequencing fetch/decode/exec/mem/wb,
// trapping on illegal opcodes and on memory acknowledge timeouts.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;

    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;

    state_t          r_state;
    logic [31:0]     r_ir;
    logic [CW-1:0]   r_cnt;
    logic [6:0]      w_op;
    logic            w_lui, w_auipc, w_jal, w_jalr, w_br, w_load, w_store, w_imm, w_opr;
    logic            w_legal, w_cnt_max, w_run;

    assign w_op      = r_ir[6:0];
    assign w_lui     = w_op == OP_LUI;
    assign w_auipc   = w_op == OP_AUIPC;
    assign w_jal     = w_op == OP_JAL;
    assign w_jalr    = w_op == OP_JALR;
    assign w_br      = w_op == OP_BR;
    assign w_load    = w_op == OP_LOAD;
    assign w_store   = w_op == OP_STORE;
    assign w_imm     = w_op == OP_IMM;
    assign w_opr     = w_op == OP_OP;
    assign w_legal   = w_lui | w_auipc | w_jal | w_jalr | w_br | w_load | w_store | w_imm | w_opr;
    assign w_cnt_max = r_cnt == CW'(TIMEOUT - 1);
    assign w_run     = !rst;

    // The wait counter covers the req cycles; an ack in the last allowed cycle still wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_ir    <= 32'h0000_0013;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        r_ir    <= bus.imem_rdata;
                        r_state <= DECODE;
                        r_cnt   <= '0;
                    end else if (w_cnt_max) begin
                        r_state <= TRAP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DECODE: r_state <= w_legal ? EXEC : TRAP;
                EXEC: begin
                    r_state <= (w_load | w_store) ? MEM : w_br ? FETCH : WB;
                    r_cnt   <= '0;
                end
                MEM: begin
                    if (bus.dmem_ack) begin
                        r_state <= w_store ? FETCH : WB;
                        r_cnt   <= '0;
                    end else if (w_cnt_max) begin
                        r_state <= TRAP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                WB: begin
                    r_state <= FETCH;
                    r_cnt   <= '0;
                end
                TRAP:    r_state <= TRAP;
                default: r_state <= TRAP;
            endcase
        end
    end

    // Requests and strobes are gated by rst so a pending access is dropped in the reset cycle.
    assign bus.imem_req  = w_run && r_state == FETCH;
    assign bus.dmem_req  = w_run && r_state == MEM;
    assign bus.dmem_we   = bus.dmem_req && w_store;
    assign bus.pc_we     = w_run && ((r_state == EXEC && w_br) || (r_state == MEM && bus.dmem_ack && w_store) || r_state == WB);
    assign bus.retire    = bus.pc_we;
    assign bus.reg_we    = w_run && r_state == WB && r_ir[11:7] != 5'd0;
    assign bus.pc_sel    = w_br ? {1'b0, bus.br_taken} : w_jal ? 2'b01 : w_jalr ? 2'b10 : 2'b00;
    assign bus.wb_sel    = (w_jal | w_jalr) ? 2'b10 : w_lui ? 2'b11 : w_load ? 2'b01 : 2'b00;
    assign bus.alu_a_sel = w_auipc | w_jal | w_br;
    assign bus.alu_b_sel = w_legal && !w_opr && !w_br;
    assign bus.ir        = r_ir;
    assign bus.opcode    = w_op;
    assign bus.trap      = r_state == TRAP;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized instruction streams against a per-instruction cycle model.
module tb_multicycle_ctrl;
    localparam int TO = 16;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] BR = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011, OPIMM = 7'b0010011, OPR = 7'b0110011;

    typedef struct packed {
        logic       legal;
        logic       mem;
        logic       store;
        logic       br;
        logic       a;
        logic       b;
        logic [1:0] wb;
        logic [1:0] pc;
    } info_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    logic [6:0] ops [9] = '{LUI, AUIPC, JAL, JALR, BR, LOAD, STORE, OPIMM, OPR};

    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] obs();
        return {bus.state, bus.imem_req, bus.dmem_req, bus.pc_we, bus.reg_we, bus.retire, bus.trap};
    endfunction

    // Instruction-class table: what each opcode asks of the datapath.
    function automatic info_t classify(input logic [6:0] op, input logic bt);
        info_t d = '0;
        d.legal = 1'b1;
        case (op)
            LUI:   begin d.b = 1; d.wb = 2'b11; end
            AUIPC: begin d.a = 1; d.b = 1; end
            JAL:   begin d.a = 1; d.b = 1; d.wb = 2'b10; d.pc = 2'b01; end
            JALR:  begin d.b = 1; d.wb = 2'b10; d.pc = 2'b10; end
            BR:    begin d.a = 1; d.br = 1; d.pc = bt ? 2'b01 : 2'b00; end
            LOAD:  begin d.b = 1; d.mem = 1; d.wb = 2'b01; end
            STORE: begin d.b = 1; d.mem = 1; d.store = 1; end
            OPIMM: d.b = 1;
            OPR:   ;
            default: d = '0;
        endcase
        return d;
    endfunction

    task automatic cyc(input string tag, input logic [2:0] st, input logic ireq, dreq, pwe, rwe, ret, trp);
        #1 check(tag, 32'(obs()), 32'({st, ireq, dreq, pwe, rwe, ret, trp}));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1 check("rst_same_cycle", 32'({bus.imem_req, bus.dmem_req, bus.pc_we, bus.reg_we, bus.retire}), 32'd0);
        @(negedge clk);
        #1 check("rst_out", 32'(obs()), 32'd0);
        check("rst_ir", bus.ir, 32'h0000_0013);
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        rst = 1'b0;
    endtask

    task automatic trap_hold();
        repeat (3) cyc("trap", 3'd5, 0, 0, 0, 0, 0, 1);
        do_reset();
    endtask

    task automatic run(input logic [31:0] insn, input int di, input int dd, input logic bt);
        info_t d   = classify(insn[6:0], bt);
        logic  rwe = insn[11:7] != 5'd0;
        bus.br_taken = bt;
        for (int k = 0; k <= di && k < TO; k++) begin
            bus.imem_ack   = (k == di);
            bus.imem_rdata = (k == di) ? insn : $urandom();
            cyc("fetch", 3'd0, 1, 0, 0, 0, 0, 0);
        end
        bus.imem_ack = 1'b0;
        if (di >= TO) begin trap_hold(); return; end
        #1 check("ir", bus.ir, insn);
        check("sel", 32'({bus.opcode, bus.alu_a_sel, bus.alu_b_sel, bus.wb_sel, bus.pc_sel}), 32'({insn[6:0], d.a, d.b, d.wb, d.pc}));
        cyc("decode", 3'd1, 0, 0, 0, 0, 0, 0);
        if (!d.legal) begin trap_hold(); return; end
        cyc("exec", 3'd2, 0, 0, d.br, 0, d.br, 0);
        if (d.br) return;
        if (d.mem) begin
            for (int k = 0; k <= dd && k < TO; k++) begin
                bus.dmem_ack = (k == dd);
                #1 check("dmem_we", 32'(bus.dmem_we), 32'(d.store));
                cyc("mem", 3'd3, 0, 1, d.store && k == dd, 0, d.store && k == dd, 0);
            end
            bus.dmem_ack = 1'b0;
            if (dd >= TO) begin trap_hold(); return; end
            if (d.store) return;
        end
        #1 check("wb_sel", 32'({bus.wb_sel, bus.pc_sel}), 32'({d.wb, d.pc}));
        cyc("wb", 3'd4, 0, 0, 1, rwe, 1, 0);
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ack = 1'b0;
        bus.br_taken = 1'b0;
        @(negedge clk);
        do_reset();
        run(32'h0050_0093, 0, 0, 1'b0);
        run(32'h0000_0463, 0, 0, 1'b1);
        run(32'h0000_0463, 2, 0, 1'b0);
        run(32'h0000_2103, 0, 3, 1'b0);
        run(32'h0020_a023, 1, 0, 1'b0);
        run(32'h0050_0013, 0, 0, 1'b0);
        run(32'h0050_0093, TO - 1, 0, 1'b0);
        run(32'h0000_2103, 0, TO - 1, 1'b0);
        run(32'h0050_0093, TO, 0, 1'b0);
        run(32'h0000_0000, 0, 0, 1'b0);
        run(32'h0000_2103, 0, TO, 1'b0);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h0000_2103;
        cyc("mid_fetch", 3'd0, 1, 0, 0, 0, 0, 0);
        bus.imem_ack = 1'b0;
        cyc("mid_decode", 3'd1, 0, 0, 0, 0, 0, 0);
        cyc("mid_exec", 3'd2, 0, 0, 0, 0, 0, 0);
        cyc("mid_mem", 3'd3, 0, 1, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 60; i++) begin
            logic [31:0] r  = $urandom();
            logic [6:0]  op = ($urandom_range(0, 9) == 0) ? r[6:0] : ops[$urandom_range(0, 8)];
            int di = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            int dd = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            run({r[31:7], op}, di, dd, 1'($urandom_range(0, 1)));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
